ws2812_led: RTL and testbench

Serial driver for a chain of WS2812-class addressable RGB LEDs. It takes a parallel image of 24 bits per LED and emits the one-wire NRZ pulse stream on a single output pin. The frame is refreshed continuously, with a latch gap between frames. It sits between the pattern or register logic and the board pin, running from the 25 MHz system clock.

---
 rtl/ws2812_pkg.sv | 26 ++
 rtl/ws2812_bit_tx.sv | 90 +++++++++
 rtl/ws2812_led.sv | 148 ++++++++++++++
 tb/tb_ws2812_led.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
// Shared constants and types for the WS2812 serial LED driver.
//   - Default pulse timing in 25 MHz clock cycles.
//   - Bits per LED (G, R, B bytes).
//   - Frame sequencer state encoding.
// ---------------------------------------------------------------------------
package ws2812_pkg;

    localparam int BITS_PER_LED       = 24;
    localparam int DEF_T0H_CYCLES     = 10;    // 400 ns
    localparam int DEF_T1H_CYCLES     = 20;    // 800 ns
    localparam int DEF_BIT_CYCLES     = 31;    // 1.24 us
    localparam int DEF_RESET_CYCLES   = 1500;  // 60 us latch gap

    typedef enum logic [1:0] {
        GAP  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// ---------------------------------------------------------------------------
// ws2812_bit_tx
// Generates one NRZ bit cell: high for T0H or T1H cycles depending on the
// bit value, then low until BIT cycles have elapsed.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   i_bit        : bit value, sampled on the clock where i_start is high
//   i_start      : begins a new bit cell on the next clock
//   o_pulse      : registered serial output level
//   o_high_last  : high during the last high cycle of the cell
//   o_done       : high during the last cycle of the cell; asserting
//                  i_start in that cycle gives seamless back-to-back bits
// ---------------------------------------------------------------------------
module ws2812_bit_tx #(
    parameter int T0H   = 10,
    parameter int T1H   = 20,
    parameter int BIT   = 31,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic i_bit,
    input  logic i_start,
    output logic o_pulse,
    output logic o_high_last,
    output logic o_done
);

    localparam logic [CNT_W-1:0] C_T0H      = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] C_T1H      = CNT_W'(T1H);
    localparam logic [CNT_W-1:0] C_BIT_LAST = CNT_W'(BIT - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    logic             r_busy;
    logic             r_bit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             r_high_last;
    logic             r_done;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_high_len;
    logic [CNT_W-1:0] w_start_len;

    assign w_cnt_nxt   = r_cnt + C_ONE;
    assign w_high_len  = r_bit ? C_T1H : C_T0H;
    assign w_start_len = i_bit ? C_T1H : C_T0H;

    // Bit cell timer: r_cnt is the index of the current cycle within the cell;
    // strobes are precomputed one cycle early so they stay registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy      <= 1'b0;
            r_bit       <= 1'b0;
            r_cnt       <= '0;
            r_pulse     <= 1'b0;
            r_high_last <= 1'b0;
            r_done      <= 1'b0;
        end else if (i_start) begin
            r_busy      <= 1'b1;
            r_bit       <= i_bit;
            r_cnt       <= '0;
            r_pulse     <= 1'b1;
            r_high_last <= (w_start_len == C_ONE);
            r_done      <= 1'b0;
        end else if (r_busy) begin
            if (r_done) begin
                r_busy      <= 1'b0;
                r_cnt       <= '0;
                r_pulse     <= 1'b0;
                r_high_last <= 1'b0;
                r_done      <= 1'b0;
            end else begin
                r_cnt       <= w_cnt_nxt;
                r_pulse     <= (w_cnt_nxt < w_high_len);
                r_high_last <= (w_cnt_nxt == (w_high_len - C_ONE));
                r_done      <= (w_cnt_nxt == C_BIT_LAST);
            end
        end else begin
            r_pulse     <= 1'b0;
            r_high_last <= 1'b0;
            r_done      <= 1'b0;
        end
    end

    assign o_pulse     = r_pulse;
    assign o_high_last = r_high_last;
    assign o_done      = r_done;

endmodule

// File: rtl/ws2812_led.sv
// ---------------------------------------------------------------------------
// ws2812_led
// Continuous-refresh serial driver for a chain of WS2812 LEDs. Sends the
// 24*LED_CNT-bit image MSB first (LED 0 in the top 24 bits), then holds the
// line low for the latch gap, and repeats forever.
// Ports:
//   clk   : system clock (25 MHz nominal)
//   reset : asynchronous active-low reset; forces led_o low immediately
//   data  : colour image, sampled only on the last cycle of each gap
//   led_o : registered serial output to the first LED
// ---------------------------------------------------------------------------
module ws2812_led
    import ws2812_pkg::*;
#(
    parameter int LED_CNT      = 1,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BITS_PER_LED*LED_CNT-1:0] data,
    output logic                          led_o
);

    localparam int DATA_W = BITS_PER_LED * LED_CNT;
    localparam int CNT_W  = $clog2(max_int(RESET_CYCLES, BIT_CYCLES) + 1);
    localparam int BCNT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0]  C_GAP_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [BCNT_W-1:0] C_BIT_TOP  = BCNT_W'(DATA_W - 1);
    localparam logic [BCNT_W-1:0] C_BIT_ONE  = BCNT_W'(1);

    generate
        if (!((T0H_CYCLES >= 1) && (T0H_CYCLES < T1H_CYCLES) &&
              (T1H_CYCLES < BIT_CYCLES) && (LED_CNT >= 1) && (RESET_CYCLES >= 1))) begin : g_bad_params
            $error("ws2812_led: illegal timing or LED_CNT parameters");
        end
    endgenerate

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_shift;
    logic [BCNT_W-1:0]   r_bit_cnt;
    logic [CNT_W-1:0]    r_gap_cnt;

    logic w_start;
    logic w_bit;
    logic w_latch;
    logic w_shift;
    logic w_pulse;
    logic w_high_last;
    logic w_done;

    ws2812_bit_tx #(
        .T0H   (T0H_CYCLES),
        .T1H   (T1H_CYCLES),
        .BIT   (BIT_CYCLES),
        .CNT_W (CNT_W)
    ) u_bit_tx (
        .clk         (clk),
        .reset       (reset),
        .i_bit       (w_bit),
        .i_start     (w_start),
        .o_pulse     (w_pulse),
        .o_high_last (w_high_last),
        .o_done      (w_done)
    );

    // Next-state and datapath controls. The bit fed to the cell generator is
    // taken from data itself at the latch point and from the next shift
    // position when chaining, so it is valid on the same edge as the start.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_bit        = r_shift[DATA_W-1];
        w_latch      = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            GAP: begin
                if (r_gap_cnt == C_GAP_LAST) begin
                    w_latch      = 1'b1;
                    w_start      = 1'b1;
                    w_bit        = data[DATA_W-1];
                    w_next_state = HIGH;
                end else begin
                    w_next_state = GAP;
                end
            end
            HIGH: begin
                if (w_high_last) begin
                    w_next_state = LOW;
                end else begin
                    w_next_state = HIGH;
                end
            end
            LOW: begin
                if (w_done) begin
                    if (r_bit_cnt == '0) begin
                        w_next_state = GAP;
                    end else begin
                        w_shift      = 1'b1;
                        w_start      = 1'b1;
                        w_bit        = r_shift[DATA_W-2];
                        w_next_state = HIGH;
                    end
                end else begin
                    w_next_state = LOW;
                end
            end
            default: begin
                w_next_state = GAP;
            end
        endcase
    end

    // State register, gap timer, shift register and bit counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= GAP;
            r_gap_cnt <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == GAP) && (r_gap_cnt != C_GAP_LAST)) begin
                r_gap_cnt <= r_gap_cnt + C_CNT_ONE;
            end else begin
                r_gap_cnt <= '0;
            end
            if (w_latch) begin
                r_shift   <= data;
                r_bit_cnt <= C_BIT_TOP;
            end else if (w_shift) begin
                r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt - C_BIT_ONE;
            end else begin
                r_shift   <= r_shift;
                r_bit_cnt <= r_bit_cnt;
            end
        end
    end

    assign led_o = w_pulse;

endmodule

// File: tb/tb_ws2812_led.sv
// ---------------------------------------------------------------------------
// tb_ws2812_led
// Self-checking bench for ws2812_led: one LED_CNT=1 instance and one
// LED_CNT=2 instance on a shared 25 MHz clock. Pulse high/low run lengths
// are measured on the output and compared with widths computed from the
// image bits and the nominal timing.
// ---------------------------------------------------------------------------
module tb_ws2812_led;

    localparam int T0   = 10;
    localparam int T1   = 20;
    localparam int BITC = 31;
    localparam int RSTC = 1500;

    logic        clk = 1'b0;
    logic        reset1;
    logic        reset2;
    logic [23:0] data1;
    logic [47:0] data2;
    logic        led1;
    logic        led2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rel1     = 0;
    int rel2     = 0;

    int cap_hw[48];
    int cap_lw[48];
    int cap_next_rise;
    bit cap_ok;

    logic [47:0] cur1;

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ws2812_led #(.LED_CNT(1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .data  (data1),
        .led_o (led1)
    );

    ws2812_led #(.LED_CNT(2)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .data  (data2),
        .led_o (led2)
    );

    // Reference model: bit i of a frame (0 = first sent) is image bit nbits-1-i.
    function automatic int exp_hw(input logic [47:0] d, input int nbits, input int i);
        return d[nbits-1-i] ? T1 : T0;
    endfunction

    // Low run after bit i; the last bit's low merges with the latch gap.
    function automatic int exp_lw(input logic [47:0] d, input int nbits, input int i);
        return BITC - exp_hw(d, nbits, i) + ((i == nbits - 1) ? RSTC : 0);
    endfunction

    function automatic logic led_of(input int sel);
        return (sel == 0) ? led1 : led2;
    endfunction

    task automatic wait_level(input int sel, input logic lvl, input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (led_of(sel) === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Measures one frame starting from a negedge sample that saw the first
    // high cycle of bit 0. Optionally changes the image at the start of
    // bit chg_bit. Ends on the sample showing the next frame's first rise.
    task automatic capture(input int sel, input int nbits, input int chg_bit, input logic [47:0] chg_d);
        int h;
        int l;
        bit fin;
        cap_ok = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) begin
                if (sel == 0) data1 = chg_d[23:0];
                else          data2 = chg_d;
            end
            h = 1;
            fin = 1'b0;
            while (!fin && h < 200) begin
                @(negedge clk);
                if (led_of(sel) === 1'b1) h++;
                else fin = 1'b1;
            end
            if (!fin) cap_ok = 1'b0;
            l = 1;
            fin = 1'b0;
            while (!fin && l < 4000) begin
                @(negedge clk);
                if (led_of(sel) === 1'b1) fin = 1'b1;
                else l++;
            end
            if (!fin) cap_ok = 1'b0;
            cap_hw[i] = h;
            cap_lw[i] = l;
        end
        cap_next_rise = cyc - ((sel == 0) ? rel1 : rel2);
    endtask

    task automatic test_reset();
        reset1 = 1'b0;
        reset2 = 1'b0;
        data1  = 24'h4C55C9;
        data2  = 48'hFF00000000FF;
        #100;
        n_checks++;
        if (led1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_led1: got %b expected 0", led1);
        end
        n_checks++;
        if (led2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_led2: got %b expected 0", led2);
        end
        @(negedge clk);
        #2 reset1 = 1'b1;
        rel1 = cyc;
    endtask

    task automatic test_single_frame();
        int tbl[24] = '{10,20,10,10,20,20,10,10,10,20,10,20,10,20,10,20,20,20,10,10,20,10,10,20};
        bit ok;
        int off;
        int lw;
        wait_level(0, 1'b1, 2000, ok);
        off = cyc - rel1;
        n_checks++;
        if (!ok || off !== RSTC) begin
            n_fail++;
            $display("FAIL first_rise: got %0d (seen %0d) expected %0d", off, ok, RSTC);
        end
        capture(0, 24, -1, 48'h0);
        n_checks++;
        if (!cap_ok) begin
            n_fail++;
            $display("FAIL single_timeout: got %0d expected 1", cap_ok);
        end
        for (int i = 0; i < 24; i++) begin
            lw = BITC - tbl[i] + ((i == 23) ? RSTC : 0);
            n_checks++;
            if (cap_hw[i] !== tbl[i]) begin
                n_fail++;
                $display("FAIL single_hw bit %0d: got %0d expected %0d", i, cap_hw[i], tbl[i]);
            end
            n_checks++;
            if (cap_lw[i] !== lw) begin
                n_fail++;
                $display("FAIL single_lw bit %0d: got %0d expected %0d", i, cap_lw[i], lw);
            end
        end
        n_checks++;
        if (cap_next_rise !== 3744) begin
            n_fail++;
            $display("FAIL frame2_start: got %0d expected 3744", cap_next_rise);
        end
        cur1 = 48'h4C55C9;
    endtask

    task automatic test_refresh();
        capture(0, 24, -1, 48'h0);
        n_checks++;
        if (!cap_ok) begin
            n_fail++;
            $display("FAIL refresh_timeout: got %0d expected 1", cap_ok);
        end
        for (int i = 0; i < 24; i++) begin
            n_checks++;
            if (cap_hw[i] !== exp_hw(cur1, 24, i)) begin
                n_fail++;
                $display("FAIL refresh_hw bit %0d: got %0d expected %0d", i, cap_hw[i], exp_hw(cur1, 24, i));
            end
            n_checks++;
            if (cap_lw[i] !== exp_lw(cur1, 24, i)) begin
                n_fail++;
                $display("FAIL refresh_lw bit %0d: got %0d expected %0d", i, cap_lw[i], exp_lw(cur1, 24, i));
            end
        end
        n_checks++;
        if (cap_next_rise !== 5988) begin
            n_fail++;
            $display("FAIL frame3_start: got %0d expected 5988", cap_next_rise);
        end
    endtask

    task automatic test_data_change();
        capture(0, 24, 5, 48'hFFFFFF);
        for (int i = 0; i < 24; i++) begin
            n_checks++;
            if (cap_hw[i] !== exp_hw(cur1, 24, i) || cap_lw[i] !== exp_lw(cur1, 24, i)) begin
                n_fail++;
                $display("FAIL change_old bit %0d: got %0d/%0d expected %0d/%0d", i,
                         cap_hw[i], cap_lw[i], exp_hw(cur1, 24, i), exp_lw(cur1, 24, i));
            end
        end
        cur1 = 48'hFFFFFF;
        capture(0, 24, -1, 48'h0);
        for (int i = 0; i < 24; i++) begin
            n_checks++;
            if (cap_hw[i] !== T1 || cap_lw[i] !== exp_lw(cur1, 24, i)) begin
                n_fail++;
                $display("FAIL change_new bit %0d: got %0d/%0d expected %0d/%0d", i,
                         cap_hw[i], cap_lw[i], T1, exp_lw(cur1, 24, i));
            end
        end
    endtask

    task automatic test_all_zero();
        capture(0, 24, 7, 48'h0);
        for (int i = 0; i < 24; i++) begin
            n_checks++;
            if (cap_hw[i] !== exp_hw(cur1, 24, i)) begin
                n_fail++;
                $display("FAIL zero_prev bit %0d: got %0d expected %0d", i, cap_hw[i], exp_hw(cur1, 24, i));
            end
        end
        cur1 = 48'h0;
        capture(0, 24, -1, 48'h0);
        for (int i = 0; i < 24; i++) begin
            n_checks++;
            if (cap_hw[i] > T0 || cap_hw[i] !== exp_hw(cur1, 24, i) || cap_lw[i] !== exp_lw(cur1, 24, i)) begin
                n_fail++;
                $display("FAIL zero_hw bit %0d: got %0d/%0d expected %0d/%0d", i,
                         cap_hw[i], cap_lw[i], T0, exp_lw(cur1, 24, i));
            end
        end
    endtask

    task automatic test_random();
        logic [47:0] d;
        int k;
        int start;
        for (int it = 0; it < 4; it++) begin
            d = {24'h0, 24'($urandom)};
            k = (it == 3) ? -1 : int'($urandom_range(0, 23));
            start = cyc - rel1;
            capture(0, 24, k, d);
            n_checks++;
            if (!cap_ok || (cap_next_rise - start) !== (RSTC + 24 * BITC)) begin
                n_fail++;
                $display("FAIL random_period it %0d: got %0d expected %0d", it, cap_next_rise - start, RSTC + 24 * BITC);
            end
            for (int i = 0; i < 24; i++) begin
                n_checks++;
                if (cap_hw[i] !== exp_hw(cur1, 24, i) || cap_lw[i] !== exp_lw(cur1, 24, i)) begin
                    n_fail++;
                    $display("FAIL random it %0d bit %0d: got %0d/%0d expected %0d/%0d", it, i,
                             cap_hw[i], cap_lw[i], exp_hw(cur1, 24, i), exp_lw(cur1, 24, i));
                end
            end
            if (k >= 0) cur1 = d;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit all_ok;
        int off;
        all_ok = 1'b1;
        // currently on the first high sample of bit 0; advance to bit 3
        for (int b = 0; b < 3; b++) begin
            wait_level(0, 1'b0, 100, ok);
            all_ok = all_ok & ok;
            wait_level(0, 1'b1, 100, ok);
            all_ok = all_ok & ok;
        end
        @(negedge clk);
        n_checks++;
        if (!all_ok || led1 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_in_high: got %b expected 1", led1);
        end
        #5 reset1 = 1'b0;
        #1;
        n_checks++;
        if (led1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_drop: got %b expected 0", led1);
        end
        #100;
        @(negedge clk);
        #2 reset1 = 1'b1;
        rel1 = cyc;
        wait_level(0, 1'b1, 2000, ok);
        off = cyc - rel1;
        n_checks++;
        if (!ok || off !== RSTC) begin
            n_fail++;
            $display("FAIL mid_restart_rise: got %0d expected %0d", off, RSTC);
        end
        capture(0, 24, -1, 48'h0);
        for (int i = 0; i < 24; i++) begin
            n_checks++;
            if (cap_hw[i] !== exp_hw(cur1, 24, i) || cap_lw[i] !== exp_lw(cur1, 24, i)) begin
                n_fail++;
                $display("FAIL mid_frame bit %0d: got %0d/%0d expected %0d/%0d", i,
                         cap_hw[i], cap_lw[i], exp_hw(cur1, 24, i), exp_lw(cur1, 24, i));
            end
        end
    endtask

    task automatic test_multi_led();
        bit ok;
        int off;
        logic [47:0] exp2;
        logic [47:0] d2;
        exp2 = 48'hFF00000000FF;
        d2   = {16'($urandom), 32'($urandom)};
        @(negedge clk);
        #2 reset2 = 1'b1;
        rel2 = cyc;
        wait_level(1, 1'b1, 2000, ok);
        off = cyc - rel2;
        n_checks++;
        if (!ok || off !== RSTC) begin
            n_fail++;
            $display("FAIL multi_first_rise: got %0d expected %0d", off, RSTC);
        end
        capture(1, 48, 20, d2);
        for (int i = 0; i < 48; i++) begin
            n_checks++;
            if (cap_hw[i] !== exp_hw(exp2, 48, i) || cap_lw[i] !== exp_lw(exp2, 48, i)) begin
                n_fail++;
                $display("FAIL multi_frame bit %0d: got %0d/%0d expected %0d/%0d", i,
                         cap_hw[i], cap_lw[i], exp_hw(exp2, 48, i), exp_lw(exp2, 48, i));
            end
        end
        n_checks++;
        if (!cap_ok || cap_next_rise !== (2 * RSTC + 48 * BITC)) begin
            n_fail++;
            $display("FAIL multi_period: got %0d expected %0d", cap_next_rise, 2 * RSTC + 48 * BITC);
        end
        capture(1, 48, -1, 48'h0);
        for (int i = 0; i < 48; i++) begin
            n_checks++;
            if (cap_hw[i] !== exp_hw(d2, 48, i) || cap_lw[i] !== exp_lw(d2, 48, i)) begin
                n_fail++;
                $display("FAIL multi_random bit %0d: got %0d/%0d expected %0d/%0d", i,
                         cap_hw[i], cap_lw[i], exp_hw(d2, 48, i), exp_lw(d2, 48, i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_refresh();
        test_data_change();
        test_all_zero();
        test_random();
        test_reset_mid();
        test_multi_led();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
